// File: rtl/tone_period_meter_if.sv
// Bundles the square-wave input, the enable and the measurement outputs of
// tone_period_meter. The meter takes the slave view; whoever drives the
// input and consumes the result takes the master view.
interface tone_period_meter_if #(
  parameter int WIDTH = 29
);
  logic             SCLK_IN;
  logic             measure_en;
  logic [WIDTH-1:0] frequency;
  logic             freq_valid;
  logic             stable;
  logic             no_tone;

  modport master (
    output SCLK_IN, measure_en,
    input  frequency, freq_valid, stable, no_tone
  );

  modport slave (
    input  SCLK_IN, measure_en,
    output frequency, freq_valid, stable, no_tone
  );
endinterface

// File: rtl/tone_period_meter.sv
// tone_period_meter: measures the half-period of an asynchronous square wave
// and reports it in tone-generator units (half-period in CLK cycles minus 1),
// so looping the generator back returns its programmed frequency value.
// A first edge after any idle period only arms the meter; each later edge
// reports the gap since the previous one. Long silence drops back to idle.
module tone_period_meter #(
  parameter int WIDTH       = 29,
  parameter int TIMEOUT     = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input logic               CLK,
  input logic               RST_N,
  tone_period_meter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   edge_pulse;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] freq_reg, freq_next;
  logic             valid_reg, valid_next;
  logic             stable_reg, stable_next;
  logic             no_tone_reg;

  // Synchronise the raw input, then keep one extra flop of history for edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.SCLK_IN};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Both rising and falling edges mark a half-period boundary.
  assign edge_pulse = sync_reg[SYNC_STAGES-1] ^ hist_reg;

  // Next-state, gap counter and measurement update; disable overrides everything.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    freq_next   = freq_reg;
    valid_next  = 1'b0;
    stable_next = stable_reg;

    // Gap counter saturates, so a very long silence can never wrap into a bogus period.
    if (edge_pulse) begin
      cnt_next = '0;
    end else if (cnt_reg != TIMEOUT_CNT) begin
      cnt_next = cnt_reg + WIDTH'(1);
    end

    if (!bus.measure_en) begin
      // Frequency is deliberately kept so the game can still read the last note.
      state_next  = IDLE;
      cnt_next    = '0;
      stable_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (edge_pulse) begin
            state_next = ARMED;
          end
        end
        ARMED: begin
          // An edge coinciding with saturation still counts as an edge.
          if (edge_pulse) begin
            state_next  = LOCKED;
            freq_next   = cnt_reg;
            valid_next  = 1'b1;
            stable_next = 1'b0;
          end else if (cnt_reg == TIMEOUT_CNT) begin
            state_next  = IDLE;
            freq_next   = '0;
            stable_next = 1'b0;
          end
        end
        LOCKED: begin
          if (edge_pulse) begin
            freq_next   = cnt_reg;
            valid_next  = 1'b1;
            stable_next = (cnt_reg == freq_reg);
          end else if (cnt_reg == TIMEOUT_CNT) begin
            state_next  = IDLE;
            freq_next   = '0;
            stable_next = 1'b0;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and output registers; no_tone is registered from the next state so it tracks IDLE exactly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      freq_reg    <= '0;
      valid_reg   <= 1'b0;
      stable_reg  <= 1'b0;
      no_tone_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      freq_reg    <= freq_next;
      valid_reg   <= valid_next;
      stable_reg  <= stable_next;
      no_tone_reg <= (state_next == IDLE);
    end
  end

  assign bus.frequency  = freq_reg;
  assign bus.freq_valid = valid_reg;
  assign bus.stable     = stable_reg;
  assign bus.no_tone    = no_tone_reg;

endmodule

// File: tb/tb_tone_period_meter.sv
// Bench for tone_period_meter: directed square-wave stimulus with a scoreboard.
// Each input toggle pushes the report it should cause; a monitor pops and
// compares on every freq_valid pulse.
module tb_tone_period_meter;
  localparam int WIDTH   = 29;
  localparam int TIMEOUT = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tone_period_meter_if #(.WIDTH(WIDTH)) bus();

  tone_period_meter #(
    .WIDTH(WIDTH),
    .TIMEOUT(TIMEOUT),
    .SYNC_STAGES(2)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] freq;
    logic             stable;
  } exp_t;

  exp_t             exp_q[$];
  int               n_cmp     = 0;
  int               n_err     = 0;
  int               n_pulses  = 0;
  int               cyc       = 0;
  int               last_tog  = 0;
  logic             armed     = 1'b0;
  logic             have_prev = 1'b0;
  logic [WIDTH-1:0] prev_freq = '0;

  // Free-running cycle count so every measured interval is taken from real time.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic forget();
    armed     = 1'b0;
    have_prev = 1'b0;
  endtask

  // Toggle the input after hp cycles and predict the resulting report.
  task automatic toggle(input int hp);
    exp_t e;
    int   gap;
    repeat (hp) @(negedge clk);
    bus.SCLK_IN = ~bus.SCLK_IN;
    gap       = cyc - last_tog;
    last_tog  = cyc;
    if (!bus.measure_en) begin
      forget();
    end else if (!armed) begin
      armed = 1'b1;
    end else begin
      e.freq    = WIDTH'(gap - 1);
      e.stable  = have_prev && (prev_freq == e.freq);
      exp_q.push_back(e);
      prev_freq = e.freq;
      have_prev = 1'b1;
    end
    $display("toggle: SCLK_IN=%0b gap=%0d en=%0b", bus.SCLK_IN, gap, bus.measure_en);
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clk);
    check(name, WIDTH'(exp_q.size()), '0);
  endtask

  // Monitor: every report must match the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.freq_valid) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_report: got frequency %0d, expected no report", bus.frequency);
      end else begin
        e = exp_q.pop_front();
        $display("report: frequency=%0d stable=%0b (expected %0d/%0b)", bus.frequency, bus.stable, e.freq, e.stable);
        check("report_freq", bus.frequency, e.freq);
        check("report_stable", WIDTH'(bus.stable), WIDTH'(e.stable));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SCLK_IN    = 1'b0;
    bus.measure_en = 1'b1;
    #12;
    check("reset_frequency", bus.frequency, '0);
    check("reset_freq_valid", WIDTH'(bus.freq_valid), '0);
    check("reset_stable", WIDTH'(bus.stable), '0);
    check("reset_no_tone", WIDTH'(bus.no_tone), WIDTH'(1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    last_tog = cyc;

    // Loopback at frequency 9, then a step to 24.
    n_pulses = 0;
    for (int i = 0; i < 8; i++) toggle(10);
    drain("t1_drained");
    check("t1_pulses", WIDTH'(n_pulses), WIDTH'(7));
    check("t1_no_tone", WIDTH'(bus.no_tone), '0);
    for (int i = 0; i < 4; i++) toggle(25);
    drain("t2_drained");
    check("t2_frequency", bus.frequency, WIDTH'(24));

    // Silence: must still be locked shortly before the timeout, idle after it.
    repeat (84) @(negedge clk);
    check("t3_pre_no_tone", WIDTH'(bus.no_tone), '0);
    for (int i = 0; i < 40 && !bus.no_tone; i++) @(negedge clk);
    check("t3_no_tone", WIDTH'(bus.no_tone), WIDTH'(1));
    check("t3_frequency", bus.frequency, '0);
    check("t3_stable", WIDTH'(bus.stable), '0);
    forget();
    for (int i = 0; i < 3; i++) toggle(12);
    drain("t3_drained");

    // Asynchronous reset between clock edges while locked.
    for (int i = 0; i < 4; i++) toggle(8);
    if (bus.SCLK_IN) toggle(8);
    drain("t4_pre_drained");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t4_frequency", bus.frequency, '0);
    check("t4_freq_valid", WIDTH'(bus.freq_valid), '0);
    check("t4_stable", WIDTH'(bus.stable), '0);
    check("t4_no_tone", WIDTH'(bus.no_tone), WIDTH'(1));
    forget();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) toggle(6);
    drain("t4_drained");

    // Enable low for 50 cycles while the input keeps toggling.
    bus.measure_en = 1'b0;
    for (int i = 0; i < 10; i++) toggle(5);
    check("t5_no_tone", WIDTH'(bus.no_tone), WIDTH'(1));
    check("t5_frequency_held", bus.frequency, WIDTH'(5));
    check("t5_stable", WIDTH'(bus.stable), '0);
    repeat (6) @(negedge clk);
    bus.measure_en = 1'b1;
    forget();
    for (int i = 0; i < 3; i++) toggle(7);
    drain("t5_drained");

    // Maximum rate: one toggle per clock.
    n_pulses = 0;
    for (int i = 0; i < 20; i++) toggle(1);
    check("t6_freq_valid_held", WIDTH'(bus.freq_valid), WIDTH'(1));
    drain("t6_drained");
    check("t6_pulses", WIDTH'(n_pulses), WIDTH'(20));
    check("t6_frequency", bus.frequency, '0);
    check("t6_stable", WIDTH'(bus.stable), WIDTH'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
